// File: rtl/ram_bist_pkg.sv
// -----------------------------------------------------------------------------
// ram_bist_pkg
// Shared definitions for the dual-port RAM built-in test (ram_2port_bist) and
// its RAM model (ram_sdp).
//   - FSM state encoding (IDLE, WRITE, GAP, READ, DRAIN, DONE)
//   - RD_LAT: RAM read latency, 1 by default, 2 when the RAM output register
//     is enabled with `define RAM_2PORT_BIST_OUT_REG_EN
//   - error counter width and its saturation value
// -----------------------------------------------------------------------------
package ram_bist_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_WRITE = 3'd1;
    localparam state_t ST_GAP   = 3'd2;
    localparam state_t ST_READ  = 3'd3;
    localparam state_t ST_DRAIN = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

`ifdef RAM_2PORT_BIST_OUT_REG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    localparam int          ERR_W   = 16;
    localparam logic [15:0] ERR_SAT = 16'hFFFF;

endpackage

// File: rtl/ram_sdp.sv
// -----------------------------------------------------------------------------
// ram_sdp
// Simple dual-port RAM, single clock, registered read. A read of an address
// being written in the same cycle returns the old contents.
// Macro RAM_2PORT_BIST_OUT_REG_EN adds an output register (read latency 2).
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (read path only)
//   we_i/waddr_i/wdata_i   write port
//   re_i/raddr_i           read port
//   rdata_o                read data, RD_LAT cycles after re_i
// -----------------------------------------------------------------------------
module ram_sdp #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rd_q;

    // NOTE: the storage array has no reset so it maps onto RAM macros; only
    // the read registers are reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else if (re_i) begin
            rd_q <= mem_q[raddr_i];
        end
    end

`ifdef RAM_2PORT_BIST_OUT_REG_EN
    logic [DW-1:0] out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= rd_q;
        end
    end

    assign rdata_o = out_q;
`else
    assign rdata_o = rd_q;
`endif

endmodule

// File: rtl/ram_2port_bist.sv
// -----------------------------------------------------------------------------
// ram_2port_bist
// Built-in test for a simple dual-port RAM: writes word i = seed + i to
// address base + i (wrapping) for burst_len words, idles GAP_CYCLES, reads the
// window back and compares each word against the expected pattern.
// Optional macro: RAM_2PORT_BIST_OUT_REG_EN (RAM output register, RD_LAT = 2).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle request, accepted only in IDLE
//   base_addr/burst_len/seed   test window and pattern, sampled on start
//   busy                test in progress
//   done                one-cycle pulse at the end of a test
//   pass                1 when the last test saw no mismatch
//   err_cnt             mismatch count (saturating)
//   first_err_addr      address of the first mismatch, 0 if none
//   q                   raw RAM read data
// -----------------------------------------------------------------------------
module ram_2port_bist
    import ram_bist_pkg::*;
#(
    parameter int DW         = 8,
    parameter int AW         = 8,
    parameter int GAP_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW:0]      burst_len,
    input  logic [DW-1:0]    seed,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [AW-1:0]    first_err_addr,
    output logic [DW-1:0]    q
);

    // One counter serves word index, gap and drain; it must hold both
    // DEPTH and GAP_CYCLES-1.
    localparam int          CW      = (AW + 1 > 8) ? AW + 1 : 8;
    localparam logic [AW:0] DEPTH_V = {1'b1, {AW{1'b0}}};

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     base_q, base_d;
    logic [AW:0]       len_q, len_d;
    logic [DW-1:0]     seed_q, seed_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [AW-1:0]     ferr_q, ferr_d;
    logic              pass_q, pass_d;

    // Alignment pipeline: expected word and address travel beside the read.
    logic              pv_q    [RD_LAT];
    logic [DW-1:0]     pexp_q  [RD_LAT];
    logic [AW-1:0]     paddr_q [RD_LAT];

    logic [AW:0]       len_clamped;
    logic [AW-1:0]     word_addr;
    logic [DW-1:0]     word_data;
    logic              last_word;
    logic              ram_we, ram_re;
    logic [DW-1:0]     ram_rdata;

    assign len_clamped = (burst_len > DEPTH_V) ? DEPTH_V : burst_len;
    assign word_addr   = base_q + cnt_q[AW-1:0];
    assign word_data   = seed_q + DW'(cnt_q);
    assign last_word   = (cnt_q[AW:0] == len_q - 1'b1);
    assign ram_we      = (state_q == ST_WRITE);
    assign ram_re      = (state_q == ST_READ);

    ram_sdp #(.DW(DW), .AW(AW)) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (ram_we),
        .waddr_i (word_addr),
        .wdata_i (word_data),
        .re_i    (ram_re),
        .raddr_i (word_addr),
        .rdata_o (ram_rdata)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        len_d   = len_q;
        seed_d  = seed_q;
        err_d   = err_q;
        ferr_d  = ferr_q;
        pass_d  = pass_q;

        if (pv_q[RD_LAT-1] && (ram_rdata != pexp_q[RD_LAT-1])) begin
            if (err_q != ERR_SAT) begin
                err_d = err_q + 1'b1;
            end
            if (err_q == '0) begin
                ferr_d = paddr_q[RD_LAT-1];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    len_d   = len_clamped;
                    seed_d  = seed;
                    err_d   = '0;
                    ferr_d  = '0;
                    pass_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = (len_clamped == '0) ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (last_word) begin
                    cnt_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? ST_READ : ST_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_READ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READ: begin
                if (last_word) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CW'(RD_LAT - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The last comparison lands in the cycle before DONE, so err_d is final.
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            pass_d = (err_d == '0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            seed_q  <= '0;
            err_q   <= '0;
            ferr_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            len_q   <= len_d;
            seed_q  <= seed_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
            pass_q  <= pass_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pv_q[i]    <= 1'b0;
                pexp_q[i]  <= '0;
                paddr_q[i] <= '0;
            end
        end else begin
            pv_q[0]    <= ram_re;
            pexp_q[0]  <= word_data;
            paddr_q[0] <= word_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i]    <= pv_q[i-1];
                pexp_q[i]  <= pexp_q[i-1];
                paddr_q[i] <= paddr_q[i-1];
            end
        end
    end

    assign busy           = (state_q == ST_WRITE) || (state_q == ST_GAP) ||
                            (state_q == ST_READ)  || (state_q == ST_DRAIN);
    assign done           = (state_q == ST_DONE);
    assign pass           = pass_q;
    assign err_cnt        = err_q;
    assign first_err_addr = ferr_q;
    assign q              = ram_rdata;

endmodule

// File: doc/ram_2port_bist.md
# ram_2port_bist

Parametrised self-checking traffic generator and built-in test for a simple dual-port RAM. Writes a seeded incrementing pattern over a programmable address window, waits a programmable gap, reads the window back and compares every word against the expected value. Sits beside the on-chip simple dual-port RAM as its bring-up and regression exerciser. Reports busy, done, pass, error count and first failing address.

## Interface
- DW, 8: data width, 1..64
- AW, 8: address width; DEPTH = 2**AW
- GAP_CYCLES, 4: idle cycles between write and read phases, 0..255
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request; ignored unless state is IDLE
- base_addr  in  AW  first address of window; sampled on accepted start
- burst_len  in  AW+1  number of words, 0..DEPTH; sampled on accepted start
- seed  in  DW  pattern seed; sampled on accepted start
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse at end of test
- pass  out  1  valid after done: 1 when err_cnt == 0; held until next accepted start
- err_cnt  out  16  mismatches in current/last test, saturating at 16'hFFFF
- first_err_addr  out  AW  address of first mismatch; 0 if none
- q  out  DW  raw RAM read data, for observation

## Operation
- Word i (0 <= i < burst_len): address = (base_addr + i) mod DEPTH (wrap-around), data = (seed + i) mod 2**DW.
- States: IDLE -> WRITE -> GAP -> READ -> DRAIN -> DONE -> IDLE.
- IDLE: start latches base/len/seed, clears err_cnt, first_err_addr, pass; goes to WRITE. If burst_len == 0, goes directly to DONE (pass = 1, no RAM access). burst_len > DEPTH is clamped to DEPTH.
- WRITE: wren = 1, one word per cycle, burst_len cycles; then GAP.
- GAP: wren = rden = 0 for GAP_CYCLES cycles (0 = skip straight to READ).
- READ: rden = 1, one address per cycle, burst_len cycles; expected value and address pushed into a RD_LAT-deep alignment pipeline.
- DRAIN: RD_LAT cycles for last data to return; comparator active on every valid pipeline output.
- Mismatch: err_cnt increments (saturating); first_err_addr captured only on first mismatch.
- DONE: done = 1 one cycle, pass = (err_cnt == 0), state -> IDLE.
- start while busy: ignored, no effect on latched parameters.
- Sub-module read-during-write same address returns old data (not reachable in this FSM, but defined).
- Reset mid-operation: all state, counters and outputs return to reset values immediately; RAM contents undefined.

## Timing
- Reset values: busy 0, done 0, pass 0, err_cnt 0, first_err_addr 0, q 0, state IDLE.
- start at cycle T: first write at T+1; busy high from T+1.
- Read latency RD_LAT = 1 (2 with RAM_OUT_REG_EN): rden at cycle R -> q valid at R+RD_LAT.
- Total from start to done pulse: 1 + L + GAP_CYCLES + L + RD_LAT cycles for L = burst_len > 0; done at T+1 for L = 0.
- busy falls in the cycle done is high; new start accepted the cycle after done.

## Configuration
- RAM_2PORT_BIST_OUT_REG_EN defined: RAM output register stage added, RD_LAT = 2, alignment pipeline 2 deep.
- Undefined: q straight from RAM read register, RD_LAT = 1.

## Structure
- Shared package ram_bist_pkg: state enum (IDLE, WRITE, GAP, READ, DRAIN, DONE), RD_LAT constant derived from the macro, err_cnt width 16 and saturation value.
- One sub-module: ram_sdp (parametrised DW/AW simple dual-port RAM, single clock, registered read, optional output register under the same macro).

## Test plan
- base 0, len 16, seed 8'h20 -> writes 20..2F at 0..15, done at T+1+16+4+16+RD_LAT, pass 1, err_cnt 0.
- base 8'hF8, len 16, seed 0 -> addresses wrap F8..FF, 00..07; pass 1.
- len 0 -> done at T+1, no wren/rden, pass 1.
- Force one RAM bit stuck (bench override at addr 5) with base 0, len 16 -> err_cnt 1, first_err_addr 5, pass 0.
- start pulses during READ -> ignored, result unchanged; rst_n low mid-WRITE -> all outputs 0, state IDLE, fresh start then passes.
- len 256, DW 8, seed 8'hFF -> data wraps FF,00,01..; pass 1; repeat with RAM_2PORT_BIST_OUT_REG_EN, done one cycle later.
